// File: rtl/sdram_stream_writer.sv
// Packs an upstream word stream into fixed-length SDRAM write bursts. A short final
// burst is padded with masked beats.
module sdram_stream_writer #(
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BURST_LENGTH = 8
) (
    input  logic                  clk_axi,
    input  logic                  rstn_axi,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  writer_valid,
    input  logic                  writer_ready,
    output logic [ADDR_WIDTH-1:0] writer_addr,
    output logic [DATA_WIDTH-1:0] writer_data,
    output logic [1:0]            writer_dqm_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           burst_count_o
);

    localparam int unsigned CntW = $clog2(BURST_LENGTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {StIdle, StFill, StAddr, StData} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_ptr_q;
    logic [CntW-1:0]       fill_cnt_q;
    logic [CntW-1:0]       beat_q;
    logic [CntW:0]         valid_cnt_q;
    logic                  last_flag_q;
    logic [15:0]           burst_count_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] buf_mem_q [BURST_LENGTH];

    logic fill_done;
    logic burst_done;

    assign fill_done  = s_valid_i && (fill_cnt_q == LastIdx || s_last_i);
    assign burst_done = writer_ready && beat_q == LastIdx;

    always_ff @(posedge clk_axi) begin
        if (!rstn_axi) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StFill;
            StFill: if (fill_done) state_d = StAddr;
            StAddr: if (writer_ready) state_d = StData;
            StData: if (burst_done) state_d = last_flag_q ? StIdle : StFill;
            default: state_d = StIdle;
        endcase
    end

    // Beats past valid_cnt pad the burst with masked zero data.
    always_comb begin
        s_ready_o    = 1'b0;
        writer_valid = 1'b0;
        writer_data  = '0;
        writer_dqm_o = 2'b11;
        unique case (state_q)
            StFill: s_ready_o = 1'b1;
            StAddr: writer_valid = 1'b1;
            StData: begin
                writer_valid = 1'b1;
                if ({1'b0, beat_q} < valid_cnt_q) begin
                    writer_data  = buf_mem_q[beat_q];
                    writer_dqm_o = 2'b00;
                end
            end
            default: ;
        endcase
    end

    assign writer_addr   = addr_ptr_q;
    assign busy_o        = state_q != StIdle;
    assign done_o        = done_q;
    assign burst_count_o = burst_count_q;

    always_ff @(posedge clk_axi) begin
        if (state_q == StFill && s_valid_i) begin
            buf_mem_q[fill_cnt_q] <= s_data_i;
        end
    end

    always_ff @(posedge clk_axi) begin
        if (!rstn_axi) begin
            addr_ptr_q    <= '0;
            fill_cnt_q    <= '0;
            beat_q        <= '0;
            valid_cnt_q   <= '0;
            last_flag_q   <= 1'b0;
            burst_count_q <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        addr_ptr_q    <= base_addr_i & ~ADDR_WIDTH'(BURST_LENGTH - 1);
                        fill_cnt_q    <= '0;
                        burst_count_q <= '0;
                    end
                end
                StFill: begin
                    if (s_valid_i) begin
                        fill_cnt_q <= fill_cnt_q + CntW'(1);
                        if (fill_done) begin
                            valid_cnt_q <= {1'b0, fill_cnt_q} + (CntW + 1)'(1);
                            last_flag_q <= s_last_i;
                        end
                    end
                end
                StAddr: if (writer_ready) beat_q <= '0;
                StData: begin
                    if (writer_ready) begin
                        beat_q <= beat_q + CntW'(1);
                        if (beat_q == LastIdx) begin
                            addr_ptr_q    <= addr_ptr_q + ADDR_WIDTH'(BURST_LENGTH);
                            fill_cnt_q    <= '0;
                            burst_count_q <= burst_count_q + 16'd1;
                            done_q        <= last_flag_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// Directed bench for sdram_stream_writer: stimulus pushes expected writer-port beats into a
// queue, a monitor pops and compares on each handshake.
module tb_sdram_stream_writer;

    localparam int BL = 8;

    logic        clk_axi = 1'b0;
    logic        rstn_axi = 1'b0;
    logic        start_i = 1'b0;
    logic [23:0] base_addr_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [15:0] s_data_i = '0;
    logic        s_last_i = 1'b0;
    logic        writer_valid;
    logic        writer_ready = 1'b1;
    logic [23:0] writer_addr;
    logic [15:0] writer_data;
    logic [1:0]  writer_dqm_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] burst_count_o;

    sdram_stream_writer #(
        .ADDR_WIDTH  (24),
        .DATA_WIDTH  (16),
        .BURST_LENGTH(BL)
    ) dut (
        .clk_axi      (clk_axi),
        .rstn_axi     (rstn_axi),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .s_last_i     (s_last_i),
        .writer_valid (writer_valid),
        .writer_ready (writer_ready),
        .writer_addr  (writer_addr),
        .writer_data  (writer_data),
        .writer_dqm_o (writer_dqm_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .burst_count_o(burst_count_o)
    );

    always #5 clk_axi = ~clk_axi;

    typedef struct {
        bit          is_addr;
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  dqm;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Ready pattern changes just after each rising edge.
    initial begin
        forever begin
            @(posedge clk_axi);
            #1 writer_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes consume scoreboard entries; stalled outputs must hold.
    initial begin
        bit          stall_pending = 1'b0;
        logic [23:0] st_addr;
        logic [15:0] st_data;
        logic [1:0]  st_dqm;
        beat_t       e;
        forever begin
            @(negedge clk_axi);
            if (stall_pending) begin
                check("stall_hold", {writer_valid, writer_addr, writer_data[6:0]},
                      {1'b1, st_addr, st_data[6:0]});
                check("stall_hold_hi", {writer_data, writer_dqm_o}, {st_data, st_dqm});
            end
            stall_pending = writer_valid && !writer_ready && rstn_axi;
            st_addr = writer_addr;
            st_data = writer_data;
            st_dqm  = writer_dqm_o;
            if (writer_valid && writer_ready && rstn_axi) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, expected none",
                             writer_addr, writer_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_addr) check("burst_addr", 32'(writer_addr), 32'(e.addr));
                    else check("data_beat", {14'd0, writer_dqm_o, writer_data}, {14'd0, e.dqm, e.data});
                end
            end
        end
    end

    task automatic push_burst(input logic [23:0] a, input logic [15:0] first, input int nvalid);
        beat_t b;
        b = '{is_addr: 1'b1, addr: a, data: 16'h0, dqm: 2'b11};
        exp_q.push_back(b);
        for (int i = 0; i < BL; i++) begin
            if (i < nvalid) b = '{is_addr: 1'b0, addr: 24'h0, data: first + 16'(i), dqm: 2'b00};
            else b = '{is_addr: 1'b0, addr: 24'h0, data: 16'h0, dqm: 2'b11};
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start(input logic [23:0] base);
        start_i = 1'b1;
        base_addr_i = base;
        @(posedge clk_axi);
        #1 start_i = 1'b0;
    endtask

    task automatic send_stream(input logic [15:0] first, input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (i == pulse_at) do_start(24'h000800);
            s_valid_i = 1'b1;
            s_data_i  = first + 16'(i);
            s_last_i  = (i == n - 1);
            forever begin
                @(negedge clk_axi);
                if (s_ready_o) break;
                t++;
                if (t > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL word_accept_timeout: got no s_ready_o, expected acceptance");
                    break;
                end
            end
            @(posedge clk_axi);
            #1;
            s_valid_i = 1'b0;
            s_last_i  = 1'b0;
        end
    endtask

    task automatic wait_done(input int exp_bursts);
        int t = 0;
        do begin
            @(negedge clk_axi);
            t++;
        end while (!done_o && t < 3000);
        check("done_seen", 32'(done_o), 32'd1);
        check("busy_at_done", 32'(busy_o), 32'd0);
        check("burst_count", 32'(burst_count_o), 32'(exp_bursts));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk_axi);
        check("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    initial begin
        int t;
        int done_hits;
        repeat (3) @(posedge clk_axi);
        @(negedge clk_axi);
        check("rst_s_ready", 32'(s_ready_o), 32'd0);
        check("rst_writer_valid", 32'(writer_valid), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_addr", 32'(writer_addr), 32'd0);
        check("rst_data", 32'(writer_data), 32'd0);
        check("rst_burst_count", 32'(burst_count_o), 32'd0);
        check("rst_dqm", 32'(writer_dqm_o), 32'd3);
        @(posedge clk_axi);
        #1 rstn_axi = 1'b1;
        @(posedge clk_axi);
        #1;

        // One full burst, unaligned base.
        do_start(24'h000105);
        push_burst(24'h000100, 16'h1000, 8);
        send_stream(16'h1000, 8, -1);
        wait_done(1);

        // Two bursts, second padded.
        do_start(24'h000100);
        push_burst(24'h000100, 16'h2000, 8);
        push_burst(24'h000108, 16'h2008, 3);
        send_stream(16'h2000, 11, -1);
        wait_done(2);

        // Same with random backpressure.
        rand_ready = 1'b1;
        do_start(24'h000100);
        push_burst(24'h000100, 16'h2000, 8);
        push_burst(24'h000108, 16'h2008, 3);
        send_stream(16'h2000, 11, -1);
        wait_done(2);
        rand_ready = 1'b0;

        // Start pulse while busy is ignored.
        do_start(24'h000400);
        push_burst(24'h000400, 16'h4000, 8);
        push_burst(24'h000408, 16'h4008, 3);
        send_stream(16'h4000, 11, 4);
        wait_done(2);

        // Address wrap.
        do_start(24'hFFFFF8);
        push_burst(24'hFFFFF8, 16'h5000, 8);
        push_burst(24'h000000, 16'h5008, 8);
        send_stream(16'h5000, 16, -1);
        wait_done(2);

        // Last on the first word.
        do_start(24'h000013);
        push_burst(24'h000010, 16'h6000, 1);
        send_stream(16'h6000, 1, -1);
        wait_done(1);

        // Reset while beat 3 is presented.
        do_start(24'h000300);
        push_burst(24'h000300, 16'h3000, 3);
        repeat (BL - 3) void'(exp_q.pop_back());
        send_stream(16'h3000, 8, -1);
        t = 0;
        do begin
            @(negedge clk_axi);
            t++;
        end while (!(writer_valid && writer_data == 16'h3002) && t < 200);
        check("reached_beat2", 32'(writer_data), 32'h3002);
        @(posedge clk_axi);
        #1 rstn_axi = 1'b0;
        @(posedge clk_axi);
        #1 rstn_axi = 1'b1;
        @(negedge clk_axi);
        check("abort_writer_valid", 32'(writer_valid), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_s_ready", 32'(s_ready_o), 32'd0);
        check("abort_burst_count", 32'(burst_count_o), 32'd0);
        done_hits = done_o ? 1 : 0;
        repeat (5) begin
            @(negedge clk_axi);
            if (done_o) done_hits++;
        end
        check("abort_no_done", 32'(done_hits), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk_axi);
        #1;

        // Normal run after the abort.
        do_start(24'h000020);
        push_burst(24'h000020, 16'h7000, 8);
        send_stream(16'h7000, 8, -1);
        wait_done(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_stream_writer.md
SDRAM_STREAM_WRITER -- requirements
Module: sdram_stream_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 24: word-address width of writer_addr and base_addr_i.
REQ-002 Parameter DATA_WIDTH, default 16: width of stream and writer data.
REQ-003 Parameter BURST_LENGTH, default 8: data beats per SDRAM write burst; power of two, at least 2.
REQ-004 clk_axi  input  1  single clock; all logic on rising edge.
REQ-005 rstn_axi  input  1  reset; synchronous, active-low.
REQ-006 start_i  input  1  one-cycle pulse that starts a transfer; ignored while busy_o=1.
REQ-007 base_addr_i  input  ADDR_WIDTH  start word address; sampled when start_i is accepted.
REQ-008 s_valid_i  input  1  upstream stream word valid.
REQ-009 s_ready_o  output  1  stream word accepted when s_valid_i and s_ready_o are both 1.
REQ-010 s_data_i  input  DATA_WIDTH  stream word.
REQ-011 s_last_i  input  1  marks the final word of the transfer.
REQ-012 writer_valid  output  1  request to the SDRAM driver writer port.
REQ-013 writer_ready  input  1  driver writer-port ready.
REQ-014 writer_addr  output  ADDR_WIDTH  burst start address; meaningful in ADDR state.
REQ-015 writer_data  output  DATA_WIDTH  burst data beat.
REQ-016 writer_dqm_o  output  2  per-beat byte mask; 2'b00 = write both bytes, 2'b11 = mask both bytes.
REQ-017 busy_o  output  1  transfer in progress.
REQ-018 done_o  output  1  one-cycle pulse at transfer completion.
REQ-019 burst_count_o  output  16  number of bursts issued in the current or most recent transfer.

Function
REQ-020 The FSM SHALL have states IDLE, FILL, ADDR and DATA, and SHALL hold an internal buffer of BURST_LENGTH words.
REQ-021 In IDLE, start_i=1 SHALL load addr_ptr with base_addr_i with its low log2(BURST_LENGTH) bits forced to 0, clear fill_cnt and burst_count_o, set busy_o=1, and move to FILL.
REQ-022 In FILL, s_ready_o SHALL be 1; each accepted word SHALL be stored in buf[fill_cnt], and fill_cnt SHALL increment; in every other state s_ready_o SHALL be 0.
REQ-023 FILL SHALL move to ADDR on the acceptance of word BURST_LENGTH-1 or of a word with s_last_i=1, whichever comes first; valid_cnt SHALL latch fill_cnt+1 and last_flag SHALL latch s_last_i.
REQ-024 In ADDR, writer_valid SHALL be 1 and writer_addr SHALL equal addr_ptr; on writer_valid and writer_ready, the FSM SHALL move to DATA with beat=0.
REQ-025 In DATA, writer_valid SHALL be 1; for beat<valid_cnt, writer_data SHALL be buf[beat] and writer_dqm_o SHALL be 2'b00; otherwise writer_data SHALL be 0 and writer_dqm_o SHALL be 2'b11.
REQ-026 Each DATA handshake SHALL increment beat, and exactly BURST_LENGTH data beats SHALL be issued per burst regardless of valid_cnt.
REQ-027 On the final DATA handshake, addr_ptr SHALL advance by BURST_LENGTH modulo 2^ADDR_WIDTH, fill_cnt SHALL be cleared, and burst_count_o SHALL increment modulo 2^16.
REQ-028 After the final DATA handshake, if last_flag=1 the FSM SHALL go to IDLE, drive busy_o=0 and pulse done_o for one cycle; otherwise it SHALL go to FILL.
REQ-029 While writer_valid=1 and writer_ready=0, writer_addr, writer_data and writer_dqm_o SHALL remain stable.
REQ-030 writer_valid SHALL be 0 in IDLE and FILL; the block SHALL never deassert writer_valid before the handshake completes.
REQ-031 With s_last_i=1 on the first word, the block SHALL issue one burst with 1 valid beat and BURST_LENGTH-1 masked beats.
REQ-032 In FILL with s_valid_i=0, the block SHALL wait indefinitely with no timeout.

Reset
REQ-033 With rstn_axi=0 at a clock edge, the block SHALL enter IDLE, clear addr_ptr, fill_cnt, beat, valid_cnt and last_flag, and drive s_ready_o, writer_valid, busy_o and done_o to 0, writer_addr, writer_data and burst_count_o to 0, and writer_dqm_o to 2'b11.
REQ-034 Reset asserted during any state SHALL abort the transfer, discard buffered words, and not pulse done_o.

Verification (BURST_LENGTH=8)
REQ-035 start with base 0x000105, then 8 words 0x1000..0x1007 with last on the 8th -> addr beat 0x000100, 8 data beats dqm 00 in order, done_o pulse, burst_count_o=1.
REQ-036 11 words 0x2000..0x200A with last on the 11th, base 0x000100 -> bursts at 0x000100 and 0x000108; the second carries 0x2008..0x200A with dqm 00, then 5 beats data 0 with dqm 11; burst_count_o=2.
REQ-037 writer_ready toggled randomly (about 50%) during scenario 2 -> outputs held stable while stalled, and an identical beat sequence.
REQ-038 start_i pulsed mid-transfer with base 0x000800 -> ignored; addresses continue from the original base.
REQ-039 base 0xFFFFF8, 16 words with last on the 16th -> burst addresses 0xFFFFF8 then 0x000000.
REQ-040 rstn_axi low for one cycle in DATA beat 3 -> next cycle writer_valid=0, busy_o=0, s_ready_o=0, no done_o; a subsequent start runs normally.
